alu_rol_seq: RTL and testbench

ALU_ROL_SEQ -- requirements
Module: alu_rol_seq

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_rol1.sv | 10 +
 rtl/alu_rol_seq.sv | 57 +++++
 tb/tb_alu_rol_seq.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state type and default sizing for the rotate-left sequencer
package alu_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int WIDTH_DEF = 5;
  localparam int MAX_ROT_DEF = 4;
  function automatic int cnt_width(input int max_rot);
    return (max_rot < 2) ? 1 : $clog2(max_rot + 1);
  endfunction
endpackage

// File: rtl/alu_rol1.sv
// alu_rol1: combinational one-bit rotate-left of a WIDTH-bit word
// Ports: d (word in), q (d rotated left by one, MSB wraps to LSB)
module alu_rol1 #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  assign q = {d[WIDTH-2:0], d[WIDTH-1]};
endmodule

// File: rtl/alu_rol_seq.sv
// alu_rol_seq: sequential rotate-left of A by B, one bit per clock
// Ports: clk, rst_n (async active-low); start/A/B request captured in IDLE;
//        R registered result, busy (SHIFT), done (one-cycle pulse), inval (B > MAX_ROT)
module alu_rol_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_ROT = MAX_ROT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             inval
);
  localparam int CW = cnt_width(MAX_ROT);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_ROT);
  state_t state, state_nx;
  logic [WIDTH-1:0] w, w_rot;
  logic [CW-1:0] cnt;
  logic over, accept;
  alu_rol1 #(.WIDTH(WIDTH)) u_rol1 (.d(w), .q(w_rot));
  assign accept = (state == IDLE) && start;
  // only the low counter bits are loaded; the full B decides legality
  assign over = B > MAXV;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = SHIFT;
    else if (state == SHIFT && cnt == '0) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w <= '0;
      cnt <= '0;
      R <= '0;
      inval <= 1'b0;
    end else if (accept) begin
      w <= A;
      cnt <= over ? '0 : B[CW-1:0];
      inval <= over;
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        w <= w_rot;
        cnt <= cnt - CW'(1);
      end else R <= w;
    end
endmodule

// File: tb/tb_alu_rol_seq.sv
module tb_alu_rol_seq;
  localparam int W = 5;
  logic clk = 0, rst_n = 1, start = 0;
  logic [W-1:0] A = '0, B = '0, R;
  logic busy, done, inval;
  int cyc = 0, passed = 0, total = 0, n_done = 0, n_busy = 0;
  typedef struct { logic [W-1:0] r; logic inv; int due; } exp_t;
  exp_t sb[$];
  logic [W-1:0] r_prev = '0;

  alu_rol_seq #(.WIDTH(W), .MAX_ROT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .R(R), .busy(busy), .done(done), .inval(inval)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      n_done++;
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("R", R, e.r);
        check("inval", inval, e.inv);
        check("done_cycle", cyc, e.due);
      end
    end else if (rst_n) check("R_hold", R, r_prev);
    if (busy) n_busy++;
    r_prev = R;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                       input logic inv, input int k);
    int d0, b0;
    @(negedge clk);
    A = a; B = b; start = 1;
    sb.push_back('{r, inv, cyc + k + 2});
    d0 = n_done; b0 = n_busy;
    @(negedge clk);
    start = 0; A = ~a; B = ~b;
    for (int i = 0; i < 20 && n_done == d0; i++) @(negedge clk);
    check("done_seen", n_done - d0, 1);
    check("busy_cycles", n_busy - b0, k + 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("done_reached", done, 1);
  endtask

  initial begin
    int d0;
    logic [W-1:0] x;
    #1 rst_n = 0;
    #3;
    check("rst_R", R, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_inval", inval, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    issue(5'b10011, 5'd2, 5'b01110, 1'b0, 2);
    issue(5'b10110, 5'd0, 5'b10110, 1'b0, 0);
    issue(5'b00001, 5'd7, 5'b00001, 1'b1, 0);
    check("inval_held", inval, 1);
    issue(5'b01001, 5'd1, 5'b10010, 1'b0, 1);
    issue(5'b10100, 5'd5, 5'b10100, 1'b1, 0);
    issue(5'b01101, 5'd31, 5'b01101, 1'b1, 0);
    issue(5'b01101, 5'd4, 5'b10110, 1'b0, 4);
    // start held high throughout; inputs change while busy
    @(negedge clk);
    A = 5'b11000; B = 5'd4; start = 1;
    sb.push_back('{5'b01100, 1'b0, cyc + 6});
    repeat (2) @(negedge clk);
    A = 5'b00111; B = 5'd2;
    wait_done();
    A = 5'b00101; B = 5'd1;
    sb.push_back('{5'b01010, 1'b0, cyc + 4});
    @(negedge clk);
    check("no_accept_in_done", busy, 0);
    @(negedge clk);
    check("accept_after_done", busy, 1);
    start = 0;
    wait_done();
    @(negedge clk);
    // reset in the middle of a B=4 request
    A = 5'b10101; B = 5'd4; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("abort_R", R, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_inval", inval, 0);
    d0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    check("abort_R_stays", R, 0);
    issue(5'b00011, 5'd3, 5'b11000, 1'b0, 3);
    for (int a = 0; a < 32; a++)
      for (int k = 0; k <= 4; k++) begin
        x = W'(a);
        for (int j = 0; j < k; j++) x = {x[0], x[W-1:1]};
        issue(x, W'(k), W'(a), 1'b0, k);
      end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
